seq_divider: RTL



---
 rtl/seq_divider.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// An N-bit dividend is divided by an M-bit divisor behind a start/busy/done
// handshake. A result takes N+1 edges, counting the accepting edge.
// Optional feature macro: SEQ_DIVIDER_ZERO_CHECK_EN. When it is defined, a
// zero divisor bypasses the iteration, completes one edge after acceptance
// and raises div_by_zero. When it is undefined, a zero divisor runs the
// normal iteration and div_by_zero is tied low.
module seq_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  // ZDIV is reachable only when the zero-divisor shortcut is compiled in.
  typedef enum logic [1:0] {IDLE, RUN, ZDIV} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   q_reg, q_nx;      // dividend shifts out, quotient shifts in
  logic [M-1:0]   d_reg, d_nx;      // latched divisor
  logic [M-1:0]   r_reg, r_nx;      // restored partial remainder, always < D
  logic [CW-1:0]  cnt, cnt_nx;      // quotient bits still to produce
  logic           busy_nx, done_nx;
  logic [N-1:0]   quot_nx;
  logic [M-1:0]   rem_nx;

  // After each restore the partial remainder is below D, so it fits in M
  // bits. Only the shifted value needs the extra top bit for the compare.
  logic [M:0]     r_sh;
  logic           ge;
  logic [M-1:0]   r_diff;

  assign r_sh   = {r_reg, q_reg[N-1]};
  assign ge     = (r_sh >= {1'b0, d_reg});
  // The true difference is below D whenever ge holds, so M bits are exact.
  assign r_diff = r_sh[M-1:0] - d_reg;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic dbz_reg, dbz_nx;
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it unassigned (no latches).
    state_nx = state;
    q_nx     = q_reg;
    d_nx     = d_reg;
    r_nx     = r_reg;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    quot_nx  = quotient;
    rem_nx   = remainder;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    dbz_nx   = dbz_reg;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          q_nx    = dividend;
          d_nx    = divisor;
          r_nx    = '0;
          cnt_nx  = CW'(N);
          busy_nx = 1'b1;
          state_nx = RUN;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          if (divisor == '0) state_nx = ZDIV;
`endif
        end
      end
      RUN: begin
        q_nx   = (q_reg << 1) | N'(ge);
        r_nx   = ge ? r_diff : r_sh[M-1:0];
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          quot_nx  = q_nx;
          rem_nx   = r_nx;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          dbz_nx   = 1'b0;
`endif
        end
      end
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      ZDIV: begin
        // The result matches what the full iteration would give for D == 0.
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        quot_nx  = '1;
        rem_nx   = q_reg[M-1:0];
        dbz_nx   = 1'b1;
      end
`endif
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working registers are reset too. This is cheap at this size
      //       and keeps the state after an abort deterministic.
      state     <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_reg   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make all registers update together from pre-edge values.
      state     <= state_nx;
      q_reg     <= q_nx;
      d_reg     <= d_nx;
      r_reg     <= r_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      quotient  <= quot_nx;
      remainder <= rem_nx;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_reg   <= dbz_nx;
`endif
    end
  end

endmodule
